// File: rtl/timer_irq_bank_pkg.sv
// Shared constants and types for the timer/interrupt bank.
// Used by timer_chan and timer_irq_bank (optional feature macro: TIMER_BANK_RR_EN).
package timer_bank_pkg;

  localparam logic CFG_SEL_LIMIT = 1'b0;
  localparam logic CFG_SEL_CTRL  = 1'b1;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_MASK    = 2;

  typedef struct packed {
    logic mask;
    logic oneshot;
    logic en;
  } ctrl_t;

  // Channel-id width; a single channel still needs a 1-bit id field.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/timer_irq_bank_if.sv
// Config-write and interrupt handshake bundle between CPU (master) and timer bank (slave).
interface timer_irq_bank_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
);
  import timer_bank_pkg::*;

  localparam int ID_W = id_width(NUM_CH);

  logic              cfg_we;
  logic [ID_W-1:0]   cfg_ch;
  logic              cfg_sel;
  logic [CNT_W-1:0]  cfg_wdata;
  logic              irq_ack;
  logic              irq;
  logic [ID_W-1:0]   irq_id;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] overrun;

  modport master (
    output cfg_we, cfg_ch, cfg_sel, cfg_wdata, irq_ack,
    input  irq, irq_id, pending, overrun
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_sel, cfg_wdata, irq_ack,
    output irq, irq_id, pending, overrun
  );

endinterface

// File: rtl/timer_irq_bank_chan.sv
// One timer channel: counter, limit and CTRL bits; emits a one-cycle expire pulse
// during the cycle in which cnt == limit - 1.
module timer_chan
  import timer_bank_pkg::*;
#(
  parameter int CNT_W         = 32,
  parameter int DEFAULT_LIMIT = 100
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_we_limit,
  input  logic             i_we_ctrl,
  input  logic [CNT_W-1:0] i_wdata,
  output logic             o_expire,
  output logic             o_mask
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_limit;
  ctrl_t            r_ctrl;
  logic             w_expire;

  // Expiry decode; a LIMIT write in the same cycle suppresses it.
  always_comb begin
    w_expire = 1'b0;
    if (r_ctrl.en && (r_limit != '0) && !i_we_limit) begin
      w_expire = (r_cnt == (r_limit - CNT_W'(1)));
    end else begin
      w_expire = 1'b0;
    end
  end

  // Counter and limit
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt   <= '0;
      r_limit <= CNT_W'(DEFAULT_LIMIT);
    end else if (i_we_limit) begin
      r_limit <= i_wdata;
      r_cnt   <= '0;
    end else if (w_expire) begin
      r_cnt <= '0;
    end else if (r_ctrl.en && (r_limit != '0)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // CTRL bits; one-shot expiry drops enable unless a CTRL write lands on the same edge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ctrl <= '0;
    end else if (i_we_ctrl) begin
      r_ctrl.en      <= i_wdata[CTRL_EN];
      r_ctrl.oneshot <= i_wdata[CTRL_ONESHOT];
      r_ctrl.mask    <= i_wdata[CTRL_MASK];
    end else if (w_expire && r_ctrl.oneshot) begin
      r_ctrl.en <= 1'b0;
    end
  end

  assign o_expire = w_expire;
  assign o_mask   = r_ctrl.mask;

endmodule

// File: rtl/timer_irq_bank.sv
// Multi-channel timer bank with sticky pending/overrun flags and a registered irq arbiter.
// Optional macro TIMER_BANK_RR_EN selects round-robin arbitration instead of fixed priority.
module timer_irq_bank
  import timer_bank_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int CNT_W         = 32,
  parameter int DEFAULT_LIMIT = 100
) (
  input logic             clk,
  input logic             rstn,
  timer_irq_bank_if.slave bus
);

  localparam int ID_W = id_width(NUM_CH);

  logic [NUM_CH-1:0] w_we_limit;
  logic [NUM_CH-1:0] w_we_ctrl;
  logic [NUM_CH-1:0] w_expire;
  logic [NUM_CH-1:0] w_mask;
  logic [NUM_CH-1:0] w_cand;
  logic [NUM_CH-1:0] w_ack_clr;
  logic [NUM_CH-1:0] w_pending_nxt;
  logic [NUM_CH-1:0] w_overrun_nxt;
  logic [NUM_CH-1:0] r_pending;
  logic [NUM_CH-1:0] r_overrun;
  logic [ID_W-1:0]   w_winner;
  logic [ID_W-1:0]   r_irq_id;
  logic              r_irq;
  logic              r_ack_blk;
  logic              w_ack_ok;

  // Config write decode; ids that match no channel drop the write
  always_comb begin
    w_we_limit = '0;
    w_we_ctrl  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.cfg_we && (bus.cfg_ch == ID_W'(i))) begin
        w_we_ctrl[i]  = (bus.cfg_sel == CFG_SEL_CTRL);
        w_we_limit[i] = (bus.cfg_sel == CFG_SEL_LIMIT);
      end else begin
        w_we_ctrl[i]  = 1'b0;
        w_we_limit[i] = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    timer_chan #(
      .CNT_W         (CNT_W),
      .DEFAULT_LIMIT (DEFAULT_LIMIT)
    ) u_chan (
      .clk        (clk),
      .rstn       (rstn),
      .i_we_limit (w_we_limit[g]),
      .i_we_ctrl  (w_we_ctrl[g]),
      .i_wdata    (bus.cfg_wdata),
      .o_expire   (w_expire[g]),
      .o_mask     (w_mask[g])
    );
  end

  // ack_blk swallows the ack in the cycle where irq_id is still stale
  assign w_ack_ok = bus.irq_ack && r_irq && !r_ack_blk;

  // Flag update: a new expiry beats a same-cycle ack; CTRL write clears overrun
  always_comb begin
    w_ack_clr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_ack_clr[i] = w_ack_ok && (r_irq_id == ID_W'(i));
    end
    w_pending_nxt = w_expire | (r_pending & ~w_ack_clr);
    w_overrun_nxt = (r_overrun | (w_expire & r_pending)) & ~w_we_ctrl;
  end

  assign w_cand = r_pending & ~w_mask;

`ifdef TIMER_BANK_RR_EN
  logic [ID_W-1:0] r_rr_ptr;
  logic            w_found;
  logic            w_hit;

  // Round-robin search starting at r_rr_ptr
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    w_hit    = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_hit    = !w_found && w_cand[(int'(r_rr_ptr) + k) % NUM_CH];
      w_winner = w_hit ? ID_W'((int'(r_rr_ptr) + k) % NUM_CH) : w_winner;
      w_found  = w_found | w_hit;
    end
  end

  // Pointer moves past the acked channel
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rr_ptr <= '0;
    end else if (w_ack_ok) begin
      r_rr_ptr <= (r_irq_id == ID_W'(NUM_CH - 1)) ? '0 : (r_irq_id + ID_W'(1));
    end
  end
`else
  // Fixed priority, lowest index wins
  always_comb begin
    w_winner = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      w_winner = w_cand[i] ? ID_W'(i) : w_winner;
    end
  end
`endif

  // Flags and registered interrupt outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pending <= '0;
      r_overrun <= '0;
      r_irq     <= 1'b0;
      r_irq_id  <= '0;
      r_ack_blk <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      r_overrun <= w_overrun_nxt;
      r_irq     <= |w_cand;
      r_irq_id  <= w_winner;
      r_ack_blk <= w_ack_ok;
    end
  end

  assign bus.irq     = r_irq;
  assign bus.irq_id  = r_irq_id;
  assign bus.pending = r_pending;
  assign bus.overrun = r_overrun;

endmodule

// File: tb/tb_timer_irq_bank.sv
// Directed self-checking bench for timer_irq_bank (NUM_CH = 4, CNT_W = 32, DEFAULT_LIMIT = 100).
module tb_timer_irq_bank;
  import timer_bank_pkg::*;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_errors;

  timer_irq_bank_if #(.NUM_CH(4), .CNT_W(32)) bus ();

  timer_irq_bank #(.NUM_CH(4), .CNT_W(32), .DEFAULT_LIMIT(100)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int ch, input logic sel, input logic [31:0] data);
    bus.cfg_we    = 1'b1;
    bus.cfg_ch    = 2'(ch);
    bus.cfg_sel   = sel;
    bus.cfg_wdata = data;
    tick();
    bus.cfg_we    = 1'b0;
  endtask

  task automatic do_reset();
    bus.cfg_we    = 1'b0;
    bus.cfg_ch    = 2'd0;
    bus.cfg_sel   = 1'b0;
    bus.cfg_wdata = 32'd0;
    bus.irq_ack   = 1'b0;
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({bus.irq, bus.irq_id, bus.pending, bus.overrun} !== 11'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %b expected all zero", {bus.irq, bus.irq_id, bus.pending, bus.overrun});
    end
  endtask

  task automatic test_periodic();
    do_reset();
    cfg_write(0, CFG_SEL_LIMIT, 32'd5);
    cfg_write(0, CFG_SEL_CTRL, 32'h1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_checks++;
      if (bus.pending !== 4'b0000) begin
        n_errors++;
        $display("FAIL periodic_early_e%0d: pending %b expected 0000", i, bus.pending);
      end
    end
    tick();
    n_checks++;
    if (bus.pending !== 4'b0001 || bus.irq !== 1'b0) begin
      n_errors++;
      $display("FAIL periodic_first_set: pending %b irq %b expected 0001/0", bus.pending, bus.irq);
    end
    tick();
    n_checks++;
    if (bus.irq !== 1'b1 || bus.irq_id !== 2'd0) begin
      n_errors++;
      $display("FAIL periodic_irq: irq %b id %0d expected 1/0", bus.irq, bus.irq_id);
    end
    repeat (3) tick();
    n_checks++;
    if (bus.overrun !== 4'b0000) begin
      n_errors++;
      $display("FAIL periodic_no_overrun_yet: overrun %b expected 0000", bus.overrun);
    end
    tick();
    n_checks++;
    if (bus.overrun !== 4'b0001) begin
      n_errors++;
      $display("FAIL periodic_second_expiry_overrun: overrun %b expected 0001", bus.overrun);
    end
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    n_checks++;
    if (bus.pending !== 4'b0000 || bus.irq !== 1'b1) begin
      n_errors++;
      $display("FAIL periodic_ack_clear: pending %b irq %b expected 0000/1", bus.pending, bus.irq);
    end
    tick();
    n_checks++;
    if (bus.irq !== 1'b0) begin
      n_errors++;
      $display("FAIL periodic_irq_drop: irq %b expected 0", bus.irq);
    end
  endtask

  task automatic test_oneshot();
    do_reset();
    cfg_write(1, CFG_SEL_LIMIT, 32'd3);
    cfg_write(1, CFG_SEL_CTRL, 32'h3);
    tick();
    tick();
    n_checks++;
    if (bus.pending !== 4'b0000) begin
      n_errors++;
      $display("FAIL oneshot_early: pending %b expected 0000", bus.pending);
    end
    tick();
    n_checks++;
    if (bus.pending !== 4'b0010) begin
      n_errors++;
      $display("FAIL oneshot_set: pending %b expected 0010", bus.pending);
    end
    tick();
    n_checks++;
    if (bus.irq !== 1'b1 || bus.irq_id !== 2'd1) begin
      n_errors++;
      $display("FAIL oneshot_irq: irq %b id %0d expected 1/1", bus.irq, bus.irq_id);
    end
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    repeat (10) tick();
    n_checks++;
    if (bus.pending !== 4'b0000 || bus.overrun !== 4'b0000 || bus.irq !== 1'b0) begin
      n_errors++;
      $display("FAIL oneshot_single_expiry: pending %b overrun %b irq %b expected 0000/0000/0",
               bus.pending, bus.overrun, bus.irq);
    end
    cfg_write(1, CFG_SEL_CTRL, 32'h3);
    tick();
    tick();
    n_checks++;
    if (bus.pending !== 4'b0000) begin
      n_errors++;
      $display("FAIL oneshot_rearm_early: pending %b expected 0000", bus.pending);
    end
    tick();
    n_checks++;
    if (bus.pending !== 4'b0010) begin
      n_errors++;
      $display("FAIL oneshot_rearm_from_zero: pending %b expected 0010", bus.pending);
    end
  endtask

  task automatic test_limit_edges();
    do_reset();
    cfg_write(0, CFG_SEL_LIMIT, 32'd0);
    cfg_write(0, CFG_SEL_CTRL, 32'h1);
    cfg_write(1, CFG_SEL_LIMIT, 32'd1);
    cfg_write(1, CFG_SEL_CTRL, 32'h1);
    tick();
    n_checks++;
    if (bus.pending !== 4'b0010) begin
      n_errors++;
      $display("FAIL limit_one_set: pending %b expected 0010", bus.pending);
    end
    tick();
    n_checks++;
    if (bus.overrun !== 4'b0010) begin
      n_errors++;
      $display("FAIL limit_one_overrun: overrun %b expected 0010", bus.overrun);
    end
    repeat (20) tick();
    n_checks++;
    if (bus.pending !== 4'b0010) begin
      n_errors++;
      $display("FAIL limit_zero_idle: pending %b expected 0010", bus.pending);
    end
  endtask

  task automatic test_priority();
    do_reset();
    cfg_write(0, CFG_SEL_CTRL, 32'h3);
    cfg_write(2, CFG_SEL_CTRL, 32'h3);
    cfg_write(0, CFG_SEL_LIMIT, 32'd5);
    cfg_write(2, CFG_SEL_LIMIT, 32'd4);
    repeat (3) tick();
    n_checks++;
    if (bus.pending !== 4'b0000) begin
      n_errors++;
      $display("FAIL prio_early: pending %b expected 0000", bus.pending);
    end
    tick();
    n_checks++;
    if (bus.pending !== 4'b0101) begin
      n_errors++;
      $display("FAIL prio_both_set: pending %b expected 0101", bus.pending);
    end
    tick();
    n_checks++;
    if (bus.irq !== 1'b1 || bus.irq_id !== 2'd0) begin
      n_errors++;
      $display("FAIL prio_first_winner: irq %b id %0d expected 1/0", bus.irq, bus.irq_id);
    end
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    n_checks++;
    if (bus.pending !== 4'b0100 || bus.irq_id !== 2'd0) begin
      n_errors++;
      $display("FAIL prio_after_ack: pending %b id %0d expected 0100/0", bus.pending, bus.irq_id);
    end
    tick();
    n_checks++;
    if (bus.irq !== 1'b1 || bus.irq_id !== 2'd2) begin
      n_errors++;
      $display("FAIL prio_second_winner: irq %b id %0d expected 1/2", bus.irq, bus.irq_id);
    end
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    tick();
    n_checks++;
    if (bus.irq !== 1'b0 || bus.pending !== 4'b0000) begin
      n_errors++;
      $display("FAIL prio_all_served: irq %b pending %b expected 0/0000", bus.irq, bus.pending);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    cfg_write(0, CFG_SEL_LIMIT, 32'd4);
    cfg_write(0, CFG_SEL_CTRL, 32'h1);
    repeat (10) tick();
    n_checks++;
    if (bus.overrun !== 4'b0001 || bus.pending !== 4'b0001) begin
      n_errors++;
      $display("FAIL overrun_set: overrun %b pending %b expected 0001/0001", bus.overrun, bus.pending);
    end
    cfg_write(0, CFG_SEL_CTRL, 32'h1);
    n_checks++;
    if (bus.overrun !== 4'b0000) begin
      n_errors++;
      $display("FAIL overrun_ctrl_clear: overrun %b expected 0000", bus.overrun);
    end
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    n_checks++;
    if (bus.pending !== 4'b0001 || bus.overrun !== 4'b0001) begin
      n_errors++;
      $display("FAIL overrun_ack_vs_expiry: pending %b overrun %b expected 0001/0001", bus.pending, bus.overrun);
    end
    tick();
    n_checks++;
    if (bus.irq !== 1'b1) begin
      n_errors++;
      $display("FAIL overrun_irq_kept: irq %b expected 1", bus.irq);
    end
  endtask

  task automatic test_ack_handshake();
    do_reset();
    cfg_write(3, CFG_SEL_CTRL, 32'h7);
    cfg_write(1, CFG_SEL_CTRL, 32'h1);
    cfg_write(3, CFG_SEL_LIMIT, 32'd2);
    cfg_write(1, CFG_SEL_LIMIT, 32'd3);
    repeat (3) tick();
    n_checks++;
    if (bus.pending !== 4'b1010) begin
      n_errors++;
      $display("FAIL ack_setup: pending %b expected 1010", bus.pending);
    end
    tick();
    n_checks++;
    if (bus.irq !== 1'b1 || bus.irq_id !== 2'd1) begin
      n_errors++;
      $display("FAIL ack_masked_excluded: irq %b id %0d expected 1/1", bus.irq, bus.irq_id);
    end
    tick();
    bus.irq_ack = 1'b1;
    tick();
    tick();
    bus.irq_ack = 1'b0;
    n_checks++;
    if (bus.pending !== 4'b1010 || bus.overrun !== 4'b0010) begin
      n_errors++;
      $display("FAIL ack_held_two_cycles: pending %b overrun %b expected 1010/0010", bus.pending, bus.overrun);
    end
    cfg_write(1, CFG_SEL_CTRL, 32'h0);
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    tick();
    tick();
    n_checks++;
    if (bus.irq !== 1'b0 || bus.pending !== 4'b1000) begin
      n_errors++;
      $display("FAIL ack_clears_one: irq %b pending %b expected 0/1000", bus.irq, bus.pending);
    end
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    tick();
    n_checks++;
    if (bus.pending !== 4'b1000 || bus.overrun !== 4'b0000 || bus.irq !== 1'b0) begin
      n_errors++;
      $display("FAIL ack_while_idle: pending %b overrun %b irq %b expected 1000/0000/0",
               bus.pending, bus.overrun, bus.irq);
    end
    cfg_write(3, CFG_SEL_CTRL, 32'h0);
    n_checks++;
    if (bus.irq !== 1'b0) begin
      n_errors++;
      $display("FAIL unmask_not_yet: irq %b expected 0", bus.irq);
    end
    tick();
    n_checks++;
    if (bus.irq !== 1'b1 || bus.irq_id !== 2'd3) begin
      n_errors++;
      $display("FAIL unmask_irq: irq %b id %0d expected 1/3", bus.irq, bus.irq_id);
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    cfg_write(0, CFG_SEL_CTRL, 32'h1);
    cfg_write(1, CFG_SEL_CTRL, 32'h3);
    cfg_write(3, CFG_SEL_CTRL, 32'h3);
    cfg_write(1, CFG_SEL_LIMIT, 32'd2);
    cfg_write(3, CFG_SEL_LIMIT, 32'd2);
    tick();
    tick();
    n_checks++;
    if (bus.pending !== 4'b1010) begin
      n_errors++;
      $display("FAIL midreset_setup: pending %b expected 1010", bus.pending);
    end
    tick();
    #2;
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({bus.irq, bus.irq_id, bus.pending, bus.overrun} !== 11'd0) begin
      n_errors++;
      $display("FAIL midreset_async_clear: got %b expected all zero", {bus.irq, bus.irq_id, bus.pending, bus.overrun});
    end
    tick();
    rstn = 1'b1;
    cfg_write(2, CFG_SEL_CTRL, 32'h1);
    repeat (99) tick();
    n_checks++;
    if (bus.pending !== 4'b0000) begin
      n_errors++;
      $display("FAIL midreset_default_limit_early: pending %b expected 0000", bus.pending);
    end
    tick();
    n_checks++;
    if (bus.pending !== 4'b0100) begin
      n_errors++;
      $display("FAIL midreset_default_limit: pending %b expected 0100", bus.pending);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rstn     = 1'b0;
    test_reset();
    test_periodic();
    test_oneshot();
    test_limit_edges();
    test_priority();
    test_overrun();
    test_ack_handshake();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
